ila_scope_multimode: RTL and testbench
======================================

Name: ila_scope_multimode

Overview:
- Parametrised successor to the internal logic analyzer capture path.
- Samples an internal data bus every clock into an on-chip circular buffer.
- Stops after a selectable trigger condition plus a programmable holdoff, then streams the captured window out oldest-first over a valid/ready interface.
- Sits beside the debugged logic and feeds a readout bridge (UART/JTAG) or a testbench dump.

Parameters:
- DATA_WIDTH, 16, width of the sampled bus.
- ADDR_WIDTH, 10, buffer address width; DEPTH = 2**ADDR_WIDTH samples.
- HOLDOFF_WIDTH, 12, width of the holdoff request.

Ports:
- clk  in  1  sample/system clock.
- reset  in  1  asynchronous, active-low reset.
- i_arm  in  1  single-cycle pulse; starts a new capture from any state.
- i_mode  in  2  trigger source: 0 external, 1 level match, 2 rising edge, 3 immediate.
- i_trigger  in  1  external trigger; used in mode 0.
- i_mask  in  DATA_WIDTH  bit mask for modes 1 and 2.
- i_value  in  DATA_WIDTH  compare value for mode 1.
- i_holdoff  in  HOLDOFF_WIDTH  samples written after the trigger sample.
- i_data  in  DATA_WIDTH  probed signals.
- i_ready  in  1  readout consumer ready.
- o_data  out  DATA_WIDTH  readout sample.
- o_valid  out  1  o_data valid.
- o_last  out  1  marks the final (newest) sample.
- o_index  out  ADDR_WIDTH  index of o_data; 0 = oldest.
- o_trig_index  out  ADDR_WIDTH  index of the trigger sample within the readout.
- o_primed  out  1  buffer fully written since arm.
- o_triggered  out  1  trigger seen.
- o_stopped  out  1  capture stopped (readout phase or done).

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; write pointer, read pointer, counters and previous-sample register cleared. Buffer contents undefined.
- States and transitions:
  - IDLE → PRIMING on i_arm.
  - PRIMING → ARMED after DEPTH writes.
  - ARMED → HOLDOFF on a trigger hit.
  - HOLDOFF → READ once the holdoff count is exhausted.
  - READ → DONE after the o_last handshake.
  - i_arm in any state → PRIMING next cycle: waddr=0, flags cleared, o_valid forced 0.
- Writes: in PRIMING, ARMED and HOLDOFF, i_data is written at waddr every cycle; waddr increments mod DEPTH. No writes in IDLE, READ or DONE.
- Previous-sample register: updates on every write.
- o_primed: rises the cycle after the DEPTH-th write; holds until i_arm or reset.
- Trigger evaluation: ARMED only; triggers during PRIMING are ignored. The hit is evaluated combinationally on the sample being written that cycle.
  - mode 0: i_trigger == 1.
  - mode 1: (i_data & i_mask) == (i_value & i_mask).
  - mode 2: |(i_mask & i_data & ~prev).
  - mode 3: always true, so the first ARMED sample triggers.
- On a hit:
  - Latch eff_holdoff = min(i_holdoff, DEPTH-1), so the trigger sample stays in the buffer.
  - Set o_triggered next cycle.
  - Exactly eff_holdoff further samples are written. If eff_holdoff = 0, go directly to READ; the trigger sample is the last write.
- Entering READ:
  - o_stopped = 1.
  - o_trig_index = DEPTH-1-eff_holdoff, held until i_arm.
  - Read pointer = waddr, the oldest sample.
- Readout:
  - Buffer read latency is 1 cycle; o_valid asserts no later than 2 cycles after entering READ.
  - Transfer occurs when o_valid && i_ready.
  - While o_valid && !i_ready, o_data, o_index and o_last hold stable.
  - Back-to-back transfers are sustained at 1 sample/cycle when i_ready is held high.
  - o_index counts 0..DEPTH-1.
  - o_last = 1 only when o_index = DEPTH-1.
  - After the last transfer: DONE, o_valid = 0, o_stopped stays 1.
- i_arm during READ aborts the readout; no further transfers occur.
- Reset mid-capture or mid-readout returns to IDLE asynchronously.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16; i_data = free-running counter starting at 0 on the arm cycle):
- Immediate mode, holdoff 0, i_ready=1:
  - o_primed rises after 16 writes.
  - Trigger on sample 0x10, o_trig_index = 15.
  - Readout 0x01..0x10 on consecutive cycles; o_last only on 0x10.
- Level mode, mask 0xFF, value 0x40, holdoff 5:
  - Trigger on 0x40, o_trig_index = 10.
  - Readout 0x36..0x45; index 10 carries 0x40.
- Edge mode, mask 0x80, holdoff 20:
  - Clamped to 15; trigger on 0x80, o_trig_index = 0.
  - Readout 0x80..0x8F.
- External mode:
  - i_trigger pulses at cycle 5 (PRIMING) are ignored.
  - A pulse while i_data = 0x20 with holdoff 3 gives readout 0x14..0x23 and o_trig_index = 12.
- Backpressure: i_ready pseudo-random (~50%) with the level-mode setup.
  - Each of the 16 samples is delivered once, in order.
  - o_data is stable while stalled.
- Abort:
  - reset low during HOLDOFF: all outputs 0 immediately (async).
  - i_arm at readout index 6: o_valid = 0 the next cycle; new capture proceeds, o_primed = 0 until 16 writes.

Source files
------------

// File: rtl/ila_scope_multimode.sv
// ila_scope_multimode
//   Internal logic analyzer capture path. Samples i_data every clock into a
//   circular buffer of DEPTH = 2**ADDR_WIDTH entries, stops a programmable
//   number of samples after a selectable trigger, then streams the captured
//   window out oldest-first over a valid/ready interface.
//
// Ports
//   clk           sample/system clock
//   reset         asynchronous active-low reset
//   i_arm         one-cycle pulse, restarts capture from any state
//   i_mode        trigger source: 0 external, 1 level match, 2 rising edge, 3 immediate
//   i_trigger     external trigger (mode 0)
//   i_mask        bit mask for modes 1 and 2
//   i_value       compare value for mode 1
//   i_holdoff     samples written after the trigger sample (clamped to DEPTH-1)
//   i_data        probed signals
//   i_ready       readout consumer ready
//   o_data        readout sample
//   o_valid       o_data valid
//   o_last        final (newest) sample of the window
//   o_index       index of o_data within the window, 0 = oldest
//   o_trig_index  index of the trigger sample within the window
//   o_primed      buffer fully written since arm
//   o_triggered   trigger seen
//   o_stopped     capture stopped (readout or done)
module ila_scope_multimode #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int HOLDOFF_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_arm,
    input  logic [1:0]               i_mode,
    input  logic                     i_trigger,
    input  logic [DATA_WIDTH-1:0]    i_mask,
    input  logic [DATA_WIDTH-1:0]    i_value,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_ready,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_valid,
    output logic                     o_last,
    output logic [ADDR_WIDTH-1:0]    o_index,
    output logic [ADDR_WIDTH-1:0]    o_trig_index,
    output logic                     o_primed,
    output logic                     o_triggered,
    output logic                     o_stopped
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRIMING = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_HOLDOFF = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] waddr_next;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] hold_cnt;
    logic [ADDR_WIDTH-1:0] eff_holdoff;
    logic [ADDR_WIDTH-1:0] holdoff_clamped;
    logic [ADDR_WIDTH:0]   rcount;
    logic [DATA_WIDTH-1:0] prev;
    logic                  write_en;
    logic                  hit;
    logic                  issue;

    always_comb begin
        write_en   = !i_arm && (state == S_PRIMING || state == S_ARMED || state == S_HOLDOFF);
        waddr_next = waddr + ADDR_WIDTH'(1);
        // Fetch the next buffer word whenever the output register is empty or
        // being consumed this cycle; this keeps 1 sample/cycle under ready=1.
        issue      = (state == S_READ) && (!o_valid || i_ready) && !rcount[ADDR_WIDTH];
    end

    // Holdoff is clamped so the trigger sample is never overwritten.
    always_comb begin
        if (32'(i_holdoff) > 32'(DEPTH - 1)) holdoff_clamped = LAST_ADDR;
        else                                  holdoff_clamped = ADDR_WIDTH'(i_holdoff);
    end

    always_comb begin
        case (i_mode)
            2'd0:    hit = i_trigger;
            2'd1:    hit = ((i_data ^ i_value) & i_mask) == '0;
            2'd2:    hit = |(i_mask & i_data & ~prev);
            default: hit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (write_en) mem[waddr] <= i_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            waddr        <= '0;
            raddr        <= '0;
            hold_cnt     <= '0;
            eff_holdoff  <= '0;
            rcount       <= '0;
            prev         <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_index      <= '0;
            o_trig_index <= '0;
            o_primed     <= 1'b0;
            o_triggered  <= 1'b0;
            o_stopped    <= 1'b0;
        end else if (i_arm) begin
            state        <= S_PRIMING;
            waddr        <= '0;
            hold_cnt     <= '0;
            rcount       <= '0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_index      <= '0;
            o_trig_index <= '0;
            o_primed     <= 1'b0;
            o_triggered  <= 1'b0;
            o_stopped    <= 1'b0;
        end else begin
            if (write_en) begin
                waddr <= waddr_next;
                prev  <= i_data;
            end
            case (state)
                S_PRIMING: begin
                    if (waddr == LAST_ADDR) begin
                        state    <= S_ARMED;
                        o_primed <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (hit) begin
                        o_triggered <= 1'b1;
                        eff_holdoff <= holdoff_clamped;
                        hold_cnt    <= holdoff_clamped;
                        if (holdoff_clamped == '0) begin
                            // Trigger sample is the final write; waddr_next
                            // now points at the oldest sample.
                            state        <= S_READ;
                            o_stopped    <= 1'b1;
                            o_trig_index <= LAST_ADDR - holdoff_clamped;
                            raddr        <= waddr_next;
                            rcount       <= '0;
                        end else begin
                            state <= S_HOLDOFF;
                        end
                    end
                end
                S_HOLDOFF: begin
                    hold_cnt <= hold_cnt - ADDR_WIDTH'(1);
                    if (hold_cnt == ADDR_WIDTH'(1)) begin
                        state        <= S_READ;
                        o_stopped    <= 1'b1;
                        o_trig_index <= LAST_ADDR - eff_holdoff;
                        raddr        <= waddr_next;
                        rcount       <= '0;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        o_data  <= mem[raddr];
                        o_index <= rcount[ADDR_WIDTH-1:0];
                        o_last  <= (rcount[ADDR_WIDTH-1:0] == LAST_ADDR);
                        o_valid <= 1'b1;
                        raddr   <= raddr + ADDR_WIDTH'(1);
                        rcount  <= rcount + (ADDR_WIDTH+1)'(1);
                    end else if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                        if (o_last) state <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ila_scope_multimode.sv
// Testbench for ila_scope_multimode (DATA_WIDTH=8, ADDR_WIDTH=4).
// i_data counts from 0 starting with the first cycle after the arm pulse.
module tb_ila_scope_multimode;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int HW    = 12;
    localparam int DEPTH = 16;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          i_arm     = 1'b0;
    logic [1:0]    i_mode    = '0;
    logic          i_trigger = 1'b0;
    logic [DW-1:0] i_mask    = '0;
    logic [DW-1:0] i_value   = '0;
    logic [HW-1:0] i_holdoff = '0;
    logic [DW-1:0] i_data    = '0;
    logic          i_ready   = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic [AW-1:0] o_index;
    logic [AW-1:0] o_trig_index;
    logic          o_primed;
    logic          o_triggered;
    logic          o_stopped;

    always #5 clk = ~clk;

    ila_scope_multimode #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .HOLDOFF_WIDTH(HW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_arm       (i_arm),
        .i_mode      (i_mode),
        .i_trigger   (i_trigger),
        .i_mask      (i_mask),
        .i_value     (i_value),
        .i_holdoff   (i_holdoff),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .o_index     (o_index),
        .o_trig_index(o_trig_index),
        .o_primed    (o_primed),
        .o_triggered (o_triggered),
        .o_stopped   (o_stopped)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: c = cycle number since arm (first sampled cycle is 0).
    int       c        = 0;
    bit       model_on = 1'b0;
    int       cfg_mode, cfg_mask, cfg_value, cfg_trig_c;
    int       exp_k, exp_eff;
    logic [7:0] exp_win [DEPTH];
    int       xfer_cnt, first_xfer_c, last_xfer_c, got_trig;
    logic [7:0] got [DEPTH];
    bit       stall_prev;
    logic [7:0] held_data;
    logic [3:0] held_index;
    logic       held_last;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, c);
        end
    endtask

    // Trigger rule applied to sample n of the stream (sample value = n).
    function automatic bit model_hit(input int n);
        logic [7:0] s, p, m, v;
        s = 8'(n);
        p = 8'(n - 1);
        m = 8'(cfg_mask);
        v = 8'(cfg_value);
        case (cfg_mode)
            0:       return (n == 5) || (n == cfg_trig_c);
            1:       return (s & m) == (v & m);
            2:       return (m & s & ~p) != 8'h00;
            default: return 1'b1;
        endcase
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            int stop_c;
            stop_c = exp_k + exp_eff;
            check("primed",      int'(o_primed),    (c >= DEPTH) ? 1 : 0);
            check("triggered",   int'(o_triggered), (c > exp_k) ? 1 : 0);
            check("stopped",     int'(o_stopped),   (c > stop_c) ? 1 : 0);
            check("trig_index",  int'(o_trig_index), (c > stop_c) ? (DEPTH - 1 - exp_eff) : 0);
            if (c <= stop_c)
                check("valid_early", int'(o_valid), 0);
            else if (c >= stop_c + 3 && xfer_cnt < DEPTH)
                check("valid_due", int'(o_valid), 1);
            else if (xfer_cnt >= DEPTH)
                check("valid_after_done", int'(o_valid), 0);
            if (stall_prev) begin
                check("stall_valid", int'(o_valid), 1);
                check("stall_data",  int'(o_data),  int'(held_data));
                check("stall_index", int'(o_index), int'(held_index));
                check("stall_last",  int'(o_last),  int'(held_last));
            end
            stall_prev = o_valid && !i_ready;
            held_data  = o_data;
            held_index = o_index;
            held_last  = o_last;
            if (o_valid && i_ready) begin
                if (xfer_cnt < DEPTH) begin
                    check("xfer_index", int'(o_index), xfer_cnt);
                    check("xfer_data",  int'(o_data),  int'(exp_win[xfer_cnt]));
                    check("xfer_last",  int'(o_last),  (xfer_cnt == DEPTH - 1) ? 1 : 0);
                    got[xfer_cnt] = o_data;
                end else begin
                    check("extra_xfer", xfer_cnt, DEPTH - 1);
                end
                if (xfer_cnt == 0) first_xfer_c = c;
                last_xfer_c = c;
                got_trig    = int'(o_trig_index);
                xfer_cnt++;
            end
        end
    end

    task automatic start_model();
        c            = 0;
        xfer_cnt     = 0;
        first_xfer_c = 0;
        last_xfer_c  = 0;
        got_trig     = 0;
        stall_prev   = 1'b0;
        for (int j = 0; j < DEPTH; j++) got[j] = 8'h00;
        model_on     = 1'b1;
    endtask

    task automatic drive_inputs(input bit rand_ready);
        i_data    = 8'(c);
        i_trigger = (c == 5) || (c == cfg_trig_c);
        i_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},       int'(o_data), 0);
        check({tag, "_valid"},      int'(o_valid), 0);
        check({tag, "_last"},       int'(o_last), 0);
        check({tag, "_index"},      int'(o_index), 0);
        check({tag, "_trig_index"}, int'(o_trig_index), 0);
        check({tag, "_primed"},     int'(o_primed), 0);
        check({tag, "_triggered"},  int'(o_triggered), 0);
        check({tag, "_stopped"},    int'(o_stopped), 0);
    endtask

    task automatic run_capture(input int mode, input int mask, input int value,
                               input int holdoff, input int trig_c, input bit rand_ready,
                               input int reset_c, input int abort_idx);
        bit aborted;
        cfg_mode   = mode;
        cfg_mask   = mask;
        cfg_value  = value;
        cfg_trig_c = trig_c;
        exp_k      = -1;
        for (int n = DEPTH; n < 400; n++) begin
            if (model_hit(n)) begin
                exp_k = n;
                break;
            end
        end
        exp_eff = (holdoff > DEPTH - 1) ? DEPTH - 1 : holdoff;
        for (int j = 0; j < DEPTH; j++) exp_win[j] = 8'(exp_k + exp_eff - (DEPTH - 1) + j);

        @(posedge clk); #1;
        model_on  = 1'b0;
        i_mode    = 2'(mode);
        i_mask    = 8'(mask);
        i_value   = 8'(value);
        i_holdoff = 12'(holdoff);
        i_trigger = 1'b0;
        i_ready   = 1'b0;
        i_arm     = 1'b1;
        @(posedge clk); #1;
        i_arm = 1'b0;
        start_model();
        drive_inputs(rand_ready);
        aborted = 1'b0;
        while (!(xfer_cnt >= DEPTH && c >= last_xfer_c + 3)) begin
            @(posedge clk); #1;
            c++;
            drive_inputs(rand_ready);
            if (c == reset_c) begin
                #2;
                model_on = 1'b0;
                reset    = 1'b0;
                #1;
                check_all_zero("async_rst");
                @(posedge clk); #1;
                check_all_zero("held_rst");
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (abort_idx >= 0 && !aborted && o_valid && int'(o_index) == abort_idx) begin
                aborted = 1'b1;
                check("abort_xfer_count", xfer_cnt, abort_idx);
                i_arm   = 1'b1;
                i_ready = 1'b0;
                @(posedge clk); #1;
                i_arm = 1'b0;
                check("abort_valid",   int'(o_valid), 0);
                check("abort_stopped", int'(o_stopped), 0);
                check("abort_primed",  int'(o_primed), 0);
                start_model();
                drive_inputs(rand_ready);
            end
            if (c > 400) begin
                check("timeout_xfers", xfer_cnt, DEPTH);
                break;
            end
        end
        model_on = 1'b0;
    endtask

    initial begin
        // Reset state
        #17;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Immediate mode, holdoff 0
        run_capture(3, 0, 0, 0, -1, 1'b0, -1, -1);
        check("imm_k",          exp_k, 16);
        check("imm_first",      int'(got[0]),  8'h01);
        check("imm_last",       int'(got[15]), 8'h10);
        check("imm_trig_index", got_trig, 15);
        check("imm_back2back",  last_xfer_c - first_xfer_c, 15);

        // Level mode, value 0x40, holdoff 5
        run_capture(1, 8'hFF, 8'h40, 5, -1, 1'b0, -1, -1);
        check("lvl_first",      int'(got[0]),  8'h36);
        check("lvl_last",       int'(got[15]), 8'h45);
        check("lvl_at_trig",    int'(got[10]), 8'h40);
        check("lvl_trig_index", got_trig, 10);
        check("lvl_back2back",  last_xfer_c - first_xfer_c, 15);

        // Edge mode, mask 0x80, holdoff clamped from 20 to 15
        run_capture(2, 8'h80, 0, 20, -1, 1'b0, -1, -1);
        check("edge_eff",        exp_eff, 15);
        check("edge_first",      int'(got[0]),  8'h80);
        check("edge_last",       int'(got[15]), 8'h8F);
        check("edge_trig_index", got_trig, 0);

        // External mode: pulse at cycle 5 ignored, pulse on sample 0x20 used
        run_capture(0, 0, 0, 3, 32, 1'b0, -1, -1);
        check("ext_first",      int'(got[0]),  8'h14);
        check("ext_last",       int'(got[15]), 8'h23);
        check("ext_at_trig",    int'(got[12]), 8'h20);
        check("ext_trig_index", got_trig, 12);

        // Backpressure with the level setup
        run_capture(1, 8'hFF, 8'h40, 5, -1, 1'b1, -1, -1);
        check("bp_count", xfer_cnt, DEPTH);
        check("bp_first", int'(got[0]),  8'h36);
        check("bp_last",  int'(got[15]), 8'h45);

        // Asynchronous reset during HOLDOFF (trigger at 64, holdoff cycles 65..69)
        run_capture(1, 8'hFF, 8'h40, 5, -1, 1'b0, 66, -1);

        // Re-arm at readout index 6, then the new capture runs to completion
        run_capture(1, 8'hFF, 8'h40, 5, -1, 1'b0, -1, 6);
        check("rearm_first",      int'(got[0]),  8'h36);
        check("rearm_last",       int'(got[15]), 8'h45);
        check("rearm_trig_index", got_trig, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
